// File: rtl/sc_game_fsm_param.sv
// Game-control sequencer for the multi-player car game: start, ready, timed
// move steps, crash/lose, level progression and finish, with one-cycle strobes.
module sc_game_fsm_param #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_LEVELS  = 3,
  parameter int POINT_W     = 8,
  parameter int LEVEL_STEP  = 32,
  parameter int WIN_POINTS  = 128,
  parameter int TIMER_W     = 8,
  parameter int LEVEL_TIME  = 60,
  parameter int TIME_STEP   = 15,
  parameter int LOSE_TIME   = 60
) (
  input  logic                   SC_STATEMACHINE_GENERAL_CLOCK_50,
  input  logic                   SC_STATEMACHINE_GENERAL_RESET_InHigh,
  input  logic                   start_InLow,
  input  logic [NUM_PLAYERS-1:0] ready_InLow,
  input  logic                   timer_done_InLow,
  input  logic                   move_done_InLow,
  input  logic [NUM_PLAYERS-1:0] crash_InLow,
  input  logic [POINT_W-1:0]     points_InBUS,
  output logic                   clear_OutLow,
  output logic                   timer_load_OutLow,
  output logic [TIMER_W-1:0]     timer_value_OutBUS,
  output logic                   move_OutLow,
  output logic                   random_OutLow,
  output logic [2:0]             level_OutBUS,
  output logic [NUM_PLAYERS-1:0] loser_OutBUS,
  output logic [2:0]             disp_sel_OutBUS,
  output logic [3:0]             state_OutBUS
);

  localparam int LVL_SHIFT = $clog2(LEVEL_STEP);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_START     = 4'd1,
    S_GO        = 4'd2,
    S_STEP_LOAD = 4'd3,
    S_STEP_RUN  = 4'd4,
    S_MOVE      = 4'd5,
    S_WAIT      = 4'd6,
    S_LOSE_LOAD = 4'd7,
    S_LOSE_RUN  = 4'd8,
    S_FIN       = 4'd9
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             level_q, level_d;
  logic [NUM_PLAYERS-1:0] loser_q, loser_d;
  logic [NUM_PLAYERS-1:0] first_crash;
  logic [POINT_W-1:0]     pts_div;
  logic [2:0]             level_pts;

  always_ff @(posedge SC_STATEMACHINE_GENERAL_CLOCK_50 or posedge SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
      state_q <= S_RESET;
      level_q <= '0;
      loser_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      loser_q <= loser_d;
    end
  end

  // Lowest-index crashing player wins the tie; scan downward so it lands last.
  always_comb begin
    first_crash = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (!crash_InLow[i]) begin
        first_crash    = '0;
        first_crash[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pts_div = points_InBUS >> LVL_SHIFT;
    if (pts_div >= POINT_W'(NUM_LEVELS)) level_pts = 3'(NUM_LEVELS);
    else                                 level_pts = 3'(pts_div) + 3'd1;
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    loser_d = loser_q;
    case (state_q)
      S_RESET:     state_d = S_START;
      S_START: begin
        level_d = '0;
        loser_d = '0;
        if (!start_InLow) state_d = S_GO;
      end
      S_GO: if (ready_InLow == '0) begin
        state_d = S_STEP_LOAD;
        level_d = 3'd1;
      end
      S_STEP_LOAD: state_d = S_STEP_RUN;
      S_STEP_RUN:  if (!timer_done_InLow) state_d = S_MOVE;
      S_MOVE:      state_d = S_WAIT;
      S_WAIT: if (!move_done_InLow) begin
        if (crash_InLow != '1) begin
          loser_d = first_crash;
          state_d = S_LOSE_LOAD;
        end else if (int'(points_InBUS) >= WIN_POINTS) begin
          state_d = S_FIN;
        end else begin
          if (level_pts > level_q) level_d = level_pts;
          state_d = S_STEP_LOAD;
        end
      end
      S_LOSE_LOAD: state_d = S_LOSE_RUN;
      S_LOSE_RUN:  if (!timer_done_InLow) state_d = S_START;
      S_FIN:       if (!start_InLow) state_d = S_START;
      default:     state_d = S_RESET;
    endcase
    // Level and loser read as zero for the whole START visit, not just after it.
    if (state_d == S_START) begin
      level_d = '0;
      loser_d = '0;
    end
  end

  always_comb begin
    clear_OutLow       = (state_q != S_RESET);
    timer_load_OutLow  = 1'b1;
    timer_value_OutBUS = '0;
    move_OutLow        = 1'b1;
    random_OutLow      = 1'b1;
    case (state_q)
      S_STEP_LOAD: begin
        timer_load_OutLow  = 1'b0;
        timer_value_OutBUS = TIMER_W'(LEVEL_TIME - (int'(level_q) - 1) * TIME_STEP);
      end
      S_LOSE_LOAD: begin
        timer_load_OutLow  = 1'b0;
        timer_value_OutBUS = TIMER_W'(LOSE_TIME);
      end
      S_MOVE: begin
        move_OutLow   = 1'b0;
        random_OutLow = 1'b0;
      end
      default: ;
    endcase
    level_OutBUS    = level_q;
    loser_OutBUS    = loser_q;
    state_OutBUS    = state_q;
    disp_sel_OutBUS = state_q[2:0];
  end

endmodule

// File: tb/tb_sc_game_fsm_param.sv
// Randomized + directed bench for sc_game_fsm_param against a rule-level model.
module tb_sc_game_fsm_param;
  localparam int NP = 2, NL = 3, PW = 8, LSTEP = 32, WIN = 128, TW = 8;
  localparam int LTIME = 60, TSTEP = 15, LOSET = 60;

  logic clk = 1'b0;
  logic rst;
  logic start_n = 1'b1, td_n = 1'b1, md_n = 1'b1;
  logic [NP-1:0] ready_n = '1, crash_n = '1;
  logic [PW-1:0] points = '0;
  logic clear_n, tload_n, move_n, random_n;
  logic [TW-1:0] tval;
  logic [2:0] level, disp;
  logic [NP-1:0] loser;
  logic [3:0] state;

  int errors = 0, checks = 0;
  bit chk_en = 0;

  int m_st = 0;
  logic [2:0] m_lvl = '0;
  logic [NP-1:0] m_loser = '0;

  sc_game_fsm_param #(.NUM_PLAYERS(NP), .NUM_LEVELS(NL), .POINT_W(PW), .LEVEL_STEP(LSTEP),
    .WIN_POINTS(WIN), .TIMER_W(TW), .LEVEL_TIME(LTIME), .TIME_STEP(TSTEP), .LOSE_TIME(LOSET)) dut (
    .SC_STATEMACHINE_GENERAL_CLOCK_50(clk),
    .SC_STATEMACHINE_GENERAL_RESET_InHigh(rst),
    .start_InLow(start_n), .ready_InLow(ready_n), .timer_done_InLow(td_n),
    .move_done_InLow(md_n), .crash_InLow(crash_n), .points_InBUS(points),
    .clear_OutLow(clear_n), .timer_load_OutLow(tload_n), .timer_value_OutBUS(tval),
    .move_OutLow(move_n), .random_OutLow(random_n), .level_OutBUS(level),
    .loser_OutBUS(loser), .disp_sel_OutBUS(disp), .state_OutBUS(state));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Game rules as a phase number plus level/loser bookkeeping.
  function automatic void mstep(input int st, input logic [2:0] lv, input logic [NP-1:0] lo,
                                output int nst, output logic [2:0] nlv, output logic [NP-1:0] nlo);
    int pick, t;
    nst = st; nlv = lv; nlo = lo; pick = 0;
    case (st)
      0: nst = 1;
      1: if (!start_n) nst = 2;
      2: if (ready_n == '0) begin nst = 3; nlv = 1; end
      3: nst = 4;
      4: if (!td_n) nst = 5;
      5: nst = 6;
      6: if (!md_n) begin
        if (crash_n != '1) begin
          for (int i = NP - 1; i >= 0; i--) if (!crash_n[i]) pick = i;
          nlo = NP'(1) << pick;
          nst = 7;
        end else if (int'(points) >= WIN) nst = 9;
        else begin
          t = int'(points) / LSTEP + 1;
          if (t > NL) t = NL;
          if (t > int'(lv)) nlv = 3'(t);
          nst = 3;
        end
      end
      7: nst = 8;
      8: if (!td_n) nst = 1;
      9: if (!start_n) nst = 1;
      default: nst = 0;
    endcase
    if (nst == 1) begin nlv = 0; nlo = 0; end
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int nst;
    logic [2:0] nlv;
    logic [NP-1:0] nlo;
    if (rst) begin
      m_st <= 0; m_lvl <= '0; m_loser <= '0;
    end else begin
      mstep(m_st, m_lvl, m_loser, nst, nlv, nlo);
      m_st <= nst; m_lvl <= nlv; m_loser <= nlo;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("state", state, m_st);
    chk("disp_sel", disp, m_st % 8);
    chk("clear", clear_n, m_st != 0);
    chk("timer_load", tload_n, !(m_st == 3 || m_st == 7));
    chk("move", move_n, m_st != 5);
    chk("random", random_n, m_st != 5);
    chk("level", level, m_lvl);
    chk("loser", loser, m_loser);
    if (m_st == 3) chk("timer_value", tval, LTIME - (int'(m_lvl) - 1) * TSTEP);
    else if (m_st == 7) chk("timer_value", tval, LOSET);
    else if (m_st == 0) chk("timer_value", tval, 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic go_wait();  // STEP_RUN -> MOVE -> WAIT
    td_n = 1'b0; tick(); td_n = 1'b1; tick();
  endtask

  task automatic finish_wait(input logic [PW-1:0] p, input logic [NP-1:0] c);
    points = p; crash_n = c; md_n = 1'b0; tick(); md_n = 1'b1; crash_n = '1;
  endtask

  task automatic begin_game();  // START -> GO -> STEP_LOAD -> STEP_RUN
    start_n = 1'b0; ready_n = '0; tick(2); start_n = 1'b1; ready_n = '1; tick();
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    chk_en = 1;
    tick();
    chk("rst_state", state, 0); chk("rst_clear", clear_n, 0); chk("rst_level", level, 0);
    chk("rst_strobes", {tload_n, move_n, random_n}, 3'b111);
    rst = 1'b0; tick();
    chk("after_rst_state", state, 1);

    start_n = 1'b0; ready_n = 2'b01; tick(); start_n = 1'b1;
    tick(5);
    chk("go_hold", state, 2);
    ready_n = 2'b00; tick(); ready_n = '1;
    chk("step_load", state, 3); chk("tval_l1", tval, 60); chk("tload_low", tload_n, 0);
    tick();
    chk("tload_one_cycle", tload_n, 1);

    go_wait(); finish_wait(40, '1);
    chk("lvl2", level, 2); chk("tval_l2", tval, 45);
    tick(); go_wait(); finish_wait(100, '1);
    chk("lvl3", level, 3); chk("tval_l3", tval, 30);
    tick(); go_wait(); finish_wait(50, '1);
    chk("lvl_no_drop", level, 3);

    tick(); go_wait(); finish_wait(200, 2'b00);
    chk("lose_state", state, 7); chk("loser", loser, 2'b01); chk("tval_lose", tval, 60);
    tick();
    chk("lose_run_loser", loser, 2'b01);
    td_n = 1'b0; tick(); td_n = 1'b1;
    chk("lose_to_start", state, 1);

    begin_game(); go_wait(); finish_wait(128, '1);
    chk("fin", state, 9); chk("fin_level", level, 1);
    tick(3);
    chk("fin_hold_level", level, 1);
    start_n = 1'b0; tick(); start_n = 1'b1;
    chk("fin_restart", state, 1); chk("restart_level", level, 0);

    begin_game();
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      td_n = 1'b0; tick(); td_n = 1'b1; if (!move_n) cnt++;
      tick(); if (!move_n) cnt++;
      points = PW'(k * 3); md_n = 1'b0; tick(); md_n = 1'b1; if (!move_n) cnt++;
      tick(); if (!move_n) cnt++;
    end
    chk("move_strobes_10", cnt, 10);
    go_wait();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (state == 6 && move_n) cnt++; end
    chk("wait_hold_20", cnt, 20);
    finish_wait(0, '1); tick();
    #1 rst = 1'b1; #1;
    chk("midrun_rst_state", state, 0); chk("midrun_rst_clear", clear_n, 0);
    chk("midrun_rst_level", level, 0);
    tick(); rst = 1'b0; tick();
    chk("midrun_rst_start", state, 1);

    for (int n = 0; n < 4000; n++) begin
      start_n = ($urandom_range(0, 1) == 0);
      ready_n = ($urandom_range(0, 1) == 0) ? '0 : NP'($urandom);
      td_n    = ($urandom_range(0, 9) >= 3);
      md_n    = ($urandom_range(0, 9) >= 3);
      crash_n = ($urandom_range(0, 9) == 0) ? NP'($urandom) : '1;
      points  = PW'($urandom_range(0, 255));
      rst     = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sc_game_fsm_param.md
Name: sc_game_fsm_param

Overview:
- Parametrised successor of the game-control state machine for the multi-player car game.
- Sequences start, player-ready, timed move steps, crash/lose, level progression and finish for NUM_PLAYERS players and NUM_LEVELS levels.
- Drives the step timer, car-move, random-generator and display-select datapath strobes.
- Timer loading is an explicit one-cycle state, not a combinational flag; the move interval shortens per level.

Parameters:
NUM_PLAYERS, 2, number of players / lanes (1..8)
NUM_LEVELS, 3, number of levels (1..7)
POINT_W, 8, width of points bus
LEVEL_STEP, 32, points needed per level increment
WIN_POINTS, 128, points at or above which the game ends (FIN)
TIMER_W, 8, width of timer load value
LEVEL_TIME, 60, timer load value for level 1
TIME_STEP, 15, timer reduction per level above 1; must satisfy LEVEL_TIME > (NUM_LEVELS-1)*TIME_STEP
LOSE_TIME, 60, timer load value for the lose display

Ports:
SC_STATEMACHINE_GENERAL_CLOCK_50  in  1  system clock
SC_STATEMACHINE_GENERAL_RESET_InHigh  in  1  async active-high reset
start_InLow  in  1  start button, active low, level-sensitive
ready_InLow  in  NUM_PLAYERS  per-player ready, active low
timer_done_InLow  in  1  step timer expired, active low
move_done_InLow  in  1  datapath finished car move, active low
crash_InLow  in  NUM_PLAYERS  per-player crash, active low
points_InBUS  in  POINT_W  current score
clear_OutLow  out  1  datapath clear, active low
timer_load_OutLow  out  1  one-cycle timer load strobe, active low
timer_value_OutBUS  out  TIMER_W  value loaded by the timer
move_OutLow  out  1  one-cycle car-move strobe, active low
random_OutLow  out  1  one-cycle random-advance strobe, active low
level_OutBUS  out  3  current level, 1..NUM_LEVELS (0 outside play)
loser_OutBUS  out  NUM_PLAYERS  one-hot losing player, held until START
disp_sel_OutBUS  out  3  display mux select, equal to low 3 bits of the state code
state_OutBUS  out  4  state code

Behaviour:
- Reset: SC_STATEMACHINE_GENERAL_RESET_InHigh is asynchronous, active-high; the clock is SC_STATEMACHINE_GENERAL_CLOCK_50.
- Reset values: state=RESET; level=0; loser=0; clear_OutLow=0; all strobes=1; timer_value=0. Reset mid-operation aborts immediately to RESET.
- State codes: RESET=0, START=1, GO=2, STEP_LOAD=3, STEP_RUN=4, MOVE=5, WAIT=6, LOSE_LOAD=7, LOSE_RUN=8, FIN=9. Unused codes go to RESET.
- RESET: clear_OutLow=0; next state START.
- START: level<=0, loser<=0. Next state GO when start_InLow=0.
- GO: next state STEP_LOAD with level<=1 when all ready_InLow bits are 0; otherwise stay in GO.
- STEP_LOAD: lasts 1 cycle. timer_load_OutLow=0; timer_value=LEVEL_TIME-(level-1)*TIME_STEP. Next state STEP_RUN.
- STEP_RUN: next state MOVE when timer_done_InLow=0.
- MOVE: lasts 1 cycle. move_OutLow=0 and random_OutLow=0. Next state WAIT.
- WAIT: waits for move_done_InLow=0. That cycle applies the following priority:
  1. Any crash bit is 0: loser<=one-hot of the lowest-index crashing player; next state LOSE_LOAD.
  2. points>=WIN_POINTS: next state FIN.
  3. Otherwise: level<=min(points/LEVEL_STEP+1, NUM_LEVELS); level never decreases; next state STEP_LOAD.
- Crash is sampled only in WAIT when move_done_InLow=0.
- LOSE_LOAD: lasts 1 cycle. timer_load_OutLow=0; timer_value=LOSE_TIME. Next state LOSE_RUN.
- LOSE_RUN: next state START when timer_done_InLow=0.
- FIN: level is held. Next state START when start_InLow=0. This is the restart path.
- Strobes are asserted only in their 1-cycle states; they are never asserted in two consecutive cycles.
- Every other output is 1 outside RESET (clear_OutLow=1), and all outputs are registered-state decodes with no latches.
- Arithmetic: points/LEVEL_STEP is unsigned integer division; LEVEL_STEP is a power of two and is implemented as a shift.
- If timer_done_InLow=0 on entry to STEP_RUN, the transition occurs on the next edge.

Test Plan:
- Reset mid-STEP_RUN -> state=0, clear_OutLow=0, level=0; after 1 clock state=1.
- start=0, ready=2'b01 for 5 cycles -> stays in GO. ready=2'b00 -> STEP_LOAD with timer_value=60 and a single-cycle timer_load_OutLow.
- Level progression: points=40 at WAIT with move_done -> level=2 and next timer_value=45. points=100 -> level=3 and timer_value=30. Then points=50 -> level remains 3.
- Simultaneous crash_InLow=2'b00 and points=200 in WAIT -> loser=2'b01, LOSE_LOAD with timer_value=60, then START on timer_done.
- points=128, no crash -> FIN, level held. start=0 -> START with level=0.
- Check that move_OutLow and random_OutLow are low exactly 1 cycle per step over 10 steps, and that WAIT holds with move_done_InLow=1 for 20 cycles.
